// File: rtl/pc_sequencer.sv
// Fetch-side program counter: issues req/ack instruction fetches, applies
// branch/jump/jump-register redirects and delivers fetched words to decode.
module pc_sequencer #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        branch_taken,
    input  logic        jump,
    input  logic        jump_reg,
    input  logic [31:0] redir_pc,
    input  logic [31:0] branch_offset,
    input  logic [27:0] jump_field,
    input  logic [31:0] jump_reg_addr,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        fetch_valid,
    output logic [31:0] fetch_instr,
    output logic [31:0] fetch_pc,
    output logic [31:0] fetch_pc_plus4,
    output logic        addr_err
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    state_t      state, state_next;
    logic        gap, gap_next;
    logic        pend, pend_next;
    logic [31:0] pend_addr, pend_addr_next;
    logic [31:0] pc, pc_next;
    logic [31:0] pc_plus4, redir_plus4, target;
    logic        redirect, ack_acc, squash;
    logic        unused_bits;

    assign unused_bits = ^branch_offset[31:30];

    assign pc_plus4    = pc + 32'd4;
    assign redir_plus4 = redir_pc + 32'd4;
    assign redirect    = branch_taken | jump | jump_reg;
    // Acks are only meaningful against a live request; stray acks are dropped.
    assign ack_acc     = imem_req & imem_ack;
    assign squash      = pend | redirect;

    always_comb begin
        target = redir_plus4 + {branch_offset[29:0], 2'b00};
        if (jump_reg)
            target = {jump_reg_addr[31:2], 2'b00};
        else if (jump)
            target = {redir_plus4[31:28], jump_field};
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            gap   <= 1'b0;
        end else begin
            state <= state_next;
            gap   <= gap_next;
        end
    end

    // Next-state logic; gap marks the idle cycle that follows each ack
    always_comb begin
        state_next = state;
        gap_next   = gap;
        case (state)
            IDLE: begin
                state_next = stall ? HOLD : FETCH;
                gap_next   = 1'b0;
            end
            FETCH: begin
                if (ack_acc) begin
                    if (stall) begin
                        state_next = HOLD;
                        gap_next   = 1'b0;
                    end else begin
                        gap_next = 1'b1;
                    end
                end else if (gap) begin
                    gap_next = 1'b0;
                    if (stall)
                        state_next = HOLD;
                end
            end
            HOLD: begin
                gap_next = 1'b0;
                if (!stall)
                    state_next = FETCH;
            end
            default: begin
                state_next = IDLE;
                gap_next   = 1'b0;
            end
        endcase
    end

    // Output logic
    always_comb begin
        imem_req  = (state == FETCH) && !gap;
        imem_addr = pc;
    end

    // A redirect during an outstanding request waits in pend until the ack.
    always_comb begin
        pc_next        = pc;
        pend_next      = pend;
        pend_addr_next = pend_addr;
        if (imem_req) begin
            if (ack_acc) begin
                pend_next = 1'b0;
                if (redirect)
                    pc_next = target;
                else if (pend)
                    pc_next = pend_addr;
                else
                    pc_next = pc_plus4;
            end else if (redirect) begin
                pend_next      = 1'b1;
                pend_addr_next = target;
            end
        end else if (redirect) begin
            pc_next = target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc             <= RESET_ADDR;
            pend           <= 1'b0;
            pend_addr      <= 32'd0;
            fetch_valid    <= 1'b0;
            fetch_instr    <= 32'd0;
            fetch_pc       <= 32'd0;
            fetch_pc_plus4 <= 32'd0;
            addr_err       <= 1'b0;
        end else begin
            pc          <= pc_next;
            pend        <= pend_next;
            pend_addr   <= pend_addr_next;
            fetch_valid <= ack_acc && !squash;
            addr_err    <= jump_reg && (jump_reg_addr[1:0] != 2'b00);
            if (ack_acc && !squash) begin
                fetch_instr    <= imem_rdata;
                fetch_pc       <= pc;
                fetch_pc_plus4 <= pc_plus4;
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: sequential fetch, redirects, stall and
// reset-during-fetch scenarios with hand-computed expected addresses.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        branch_taken, jump, jump_reg, stall;
    logic [31:0] redir_pc, branch_offset, jump_reg_addr;
    logic [27:0] jump_field;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic        fetch_valid, addr_err;
    logic [31:0] fetch_instr, fetch_pc, fetch_pc_plus4;

    int checks = 0;
    int failures = 0;

    pc_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .branch_taken(branch_taken), .jump(jump), .jump_reg(jump_reg),
        .redir_pc(redir_pc), .branch_offset(branch_offset),
        .jump_field(jump_field), .jump_reg_addr(jump_reg_addr),
        .stall(stall),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .fetch_valid(fetch_valid), .fetch_instr(fetch_instr),
        .fetch_pc(fetch_pc), .fetch_pc_plus4(fetch_pc_plus4),
        .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    // Waits (bounded) at negedges for imem_req; ok=0 on timeout
    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Called at a negedge with imem_req high; returns at the following negedge
    task automatic ack_cycle(input logic [31:0] word);
        imem_ack   = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ack   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        branch_taken = 0; jump = 0; jump_reg = 0; stall = 0; imem_ack = 0;
        redir_pc = 0; branch_offset = 0; jump_field = 0; jump_reg_addr = 0; imem_rdata = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({imem_req, fetch_valid, addr_err} !== 3'b000 || imem_addr !== 32'h0 ||
            fetch_instr !== 32'h0 || fetch_pc !== 32'h0 || fetch_pc_plus4 !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs: req=%b valid=%b err=%b addr=%h instr=%h pc=%h pc4=%h, required all zero",
                     imem_req, fetch_valid, addr_err, imem_addr, fetch_instr, fetch_pc, fetch_pc_plus4);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_sequential();
        bit ok;
        logic [31:0] exp_addr;
        for (int i = 0; i < 3; i++) begin
            exp_addr = 32'(i * 4);
            wait_req(ok);
            checks++;
            if (!ok || imem_addr !== exp_addr) begin
                failures++;
                $display("FAIL seq_req_addr[%0d]: req=%b addr=%h, required 1/%h", i, ok, imem_addr, exp_addr);
            end
            @(negedge clk);
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== exp_addr) begin
                failures++;
                $display("FAIL seq_addr_stable[%0d]: req=%b addr=%h, required 1/%h", i, imem_req, imem_addr, exp_addr);
            end
            ack_cycle(32'hA000_0000 + 32'(i));
            checks++;
            if (fetch_valid !== 1'b1 || fetch_pc !== exp_addr || fetch_instr !== 32'hA000_0000 + 32'(i) ||
                fetch_pc_plus4 !== exp_addr + 32'd4 || imem_req !== 1'b0) begin
                failures++;
                $display("FAIL seq_deliver[%0d]: valid=%b pc=%h instr=%h pc4=%h req=%b, required 1/%h/%h/%h/0",
                         i, fetch_valid, fetch_pc, fetch_instr, fetch_pc_plus4, imem_req,
                         exp_addr, 32'hA000_0000 + 32'(i), exp_addr + 32'd4);
            end
            @(negedge clk);
            checks++;
            if (fetch_valid !== 1'b0 || fetch_pc !== exp_addr) begin
                failures++;
                $display("FAIL seq_valid_pulse[%0d]: valid=%b pc=%h, required 0/%h", i, fetch_valid, fetch_pc, exp_addr);
            end
        end
    endtask

    task automatic test_branch();
        bit ok;
        wait_req(ok);
        branch_taken = 1; redir_pc = 32'h100; branch_offset = 32'hFFFF_FFFE;
        @(negedge clk);
        branch_taken = 0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin
            failures++;
            $display("FAIL branch_hold_addr: req=%b addr=%h, required 1/0000000c", imem_req, imem_addr);
        end
        ack_cycle(32'hDEAD_0001);
        checks++;
        if (fetch_valid !== 1'b0) begin
            failures++;
            $display("FAIL branch_squash: valid=%b, required 0", fetch_valid);
        end
        wait_req(ok);
        checks++;
        if (!ok || imem_addr !== 32'hFC) begin
            failures++;
            $display("FAIL branch_target: req=%b addr=%h, required 1/000000fc", ok, imem_addr);
        end
        ack_cycle(32'h1111_0000);
        checks++;
        if (fetch_valid !== 1'b1 || fetch_pc !== 32'hFC || fetch_instr !== 32'h1111_0000) begin
            failures++;
            $display("FAIL branch_deliver: valid=%b pc=%h instr=%h, required 1/000000fc/11110000",
                     fetch_valid, fetch_pc, fetch_instr);
        end
    endtask

    task automatic test_jump_same_cycle_ack();
        bit ok;
        wait_req(ok);
        jump = 1; redir_pc = 32'h3000_0010; jump_field = 28'h000_0400;
        imem_ack = 1; imem_rdata = 32'hDEAD_0002;
        @(negedge clk);
        jump = 0; imem_ack = 0;
        checks++;
        if (fetch_valid !== 1'b0) begin
            failures++;
            $display("FAIL jump_squash: valid=%b, required 0", fetch_valid);
        end
        wait_req(ok);
        checks++;
        if (!ok || imem_addr !== 32'h3000_0400) begin
            failures++;
            $display("FAIL jump_target: req=%b addr=%h, required 1/30000400", ok, imem_addr);
        end
        ack_cycle(32'h2222_0000);
    endtask

    task automatic test_jump_reg_overwrite();
        bit ok;
        wait_req(ok);
        branch_taken = 1; redir_pc = 32'h100; branch_offset = 32'hFFFF_FFFE;
        @(negedge clk);
        branch_taken = 0;
        jump_reg = 1; jump_reg_addr = 32'h0000_2003;
        @(negedge clk);
        jump_reg = 0;
        checks++;
        if (addr_err !== 1'b1 || imem_addr !== 32'h3000_0404) begin
            failures++;
            $display("FAIL jreg_addr_err: err=%b addr=%h, required 1/30000404", addr_err, imem_addr);
        end
        @(negedge clk);
        checks++;
        if (addr_err !== 1'b0) begin
            failures++;
            $display("FAIL jreg_err_pulse: err=%b, required 0", addr_err);
        end
        ack_cycle(32'hDEAD_0003);
        checks++;
        if (fetch_valid !== 1'b0) begin
            failures++;
            $display("FAIL jreg_squash: valid=%b, required 0", fetch_valid);
        end
        wait_req(ok);
        checks++;
        if (!ok || imem_addr !== 32'h2000) begin
            failures++;
            $display("FAIL jreg_target: req=%b addr=%h, required 1/00002000", ok, imem_addr);
        end
        ack_cycle(32'h3333_0000);
    endtask

    task automatic test_wrap();
        bit ok;
        wait_req(ok);
        jump_reg = 1; jump_reg_addr = 32'hFFFF_FFFC;
        imem_ack = 1; imem_rdata = 32'hDEAD_0004;
        @(negedge clk);
        jump_reg = 0; imem_ack = 0;
        checks++;
        if (addr_err !== 1'b0) begin
            failures++;
            $display("FAIL wrap_no_err: err=%b, required 0", addr_err);
        end
        wait_req(ok);
        checks++;
        if (!ok || imem_addr !== 32'hFFFF_FFFC) begin
            failures++;
            $display("FAIL wrap_target: req=%b addr=%h, required 1/fffffffc", ok, imem_addr);
        end
        ack_cycle(32'h4444_0000);
        checks++;
        if (fetch_valid !== 1'b1 || fetch_pc !== 32'hFFFF_FFFC || fetch_pc_plus4 !== 32'h0) begin
            failures++;
            $display("FAIL wrap_deliver: valid=%b pc=%h pc4=%h, required 1/fffffffc/00000000",
                     fetch_valid, fetch_pc, fetch_pc_plus4);
        end
        wait_req(ok);
        checks++;
        if (!ok || imem_addr !== 32'h0) begin
            failures++;
            $display("FAIL wrap_next: req=%b addr=%h, required 1/00000000", ok, imem_addr);
        end
    endtask

    task automatic test_stall();
        bit ok;
        wait_req(ok);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
                failures++;
                $display("FAIL stall_keep_req[%0d]: req=%b addr=%h, required 1/00000000", i, imem_req, imem_addr);
            end
        end
        ack_cycle(32'h5555_0000);
        checks++;
        if (fetch_valid !== 1'b1 || fetch_instr !== 32'h5555_0000 || fetch_pc !== 32'h0 || imem_req !== 1'b0) begin
            failures++;
            $display("FAIL stall_deliver: valid=%b instr=%h pc=%h req=%b, required 1/55550000/00000000/0",
                     fetch_valid, fetch_instr, fetch_pc, imem_req);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (imem_req !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold[%0d]: req=%b, required 0", i, imem_req);
            end
        end
        stall = 0;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
            failures++;
            $display("FAIL stall_resume: req=%b addr=%h, required 1/00000004", imem_req, imem_addr);
        end
    endtask

    task automatic test_reset_mid_fetch();
        bit ok;
        wait_req(ok);
        rst_n = 0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h0 || fetch_valid !== 1'b0 || fetch_pc !== 32'h0) begin
            failures++;
            $display("FAIL rst_drop_req: req=%b addr=%h valid=%b pc=%h, required 0/00000000/0/00000000",
                     imem_req, imem_addr, fetch_valid, fetch_pc);
        end
        @(negedge clk);
        rst_n = 1;
        imem_ack = 1; imem_rdata = 32'hDEAD_0005;
        @(negedge clk);
        imem_ack = 0;
        checks++;
        if (fetch_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            failures++;
            $display("FAIL rst_late_ack: valid=%b req=%b addr=%h, required 0/1/00000000",
                     fetch_valid, imem_req, imem_addr);
        end
        ack_cycle(32'h6666_0000);
        checks++;
        if (fetch_valid !== 1'b1 || fetch_pc !== 32'h0 || fetch_instr !== 32'h6666_0000) begin
            failures++;
            $display("FAIL rst_first_fetch: valid=%b pc=%h instr=%h, required 1/00000000/66660000",
                     fetch_valid, fetch_pc, fetch_instr);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jump_same_cycle_ack();
        test_jump_reg_overwrite();
        test_wrap();
        test_stall();
        test_reset_mid_fetch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
